cache_rd_arbiter: RTL and testbench
===================================

// Module: cache_rd_arbiter
// PURPOSE
//  Shares the single bus read channel (rd_req/rd_type/rd_addr/rd_rdy/ret_*) between icache (port I) and dcache (port D).
//  Grants one requester at a time and forwards its request to the bus.
//  Steers return beats back to the owner and holds ownership until the burst ends.
//  Sits between the two caches and the AXI bridge; one outstanding bus read at any time.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  return data width
//  LINE_WORDS  4   beats expected for rd_type 3'b100 (line); every other type expects 1 beat
// PORTS
//  clk           in   1       clock
//  reset         in   1       asynchronous, active-low reset
//  i_rd_req      in   1       icache read request
//  i_rd_type     in   3       icache request type (3'b010 word, 3'b100 line)
//  i_rd_addr     in   ADDR_W  icache request start address
//  i_rd_rdy      out  1       icache request accepted
//  i_ret_valid   out  1       icache return beat valid
//  i_ret_last    out  1       icache last beat
//  i_ret_data    out  DATA_W  icache return data
//  d_rd_req / d_rd_type / d_rd_addr / d_rd_rdy / d_ret_valid / d_ret_last / d_ret_data   same as I port, dcache side
//  rd_req        out  1       bus read request
//  rd_type       out  3       bus request type
//  rd_addr       out  ADDR_W  bus start address
//  rd_rdy        in   1       bus accepted request
//  ret_valid     in   1       bus return beat valid
//  ret_last      in   1       bus last beat
//  ret_data      in   DATA_W  bus return data
//  owner         out  1       current owner: 0 = I, 1 = D; valid when busy
//  busy          out  1       arbiter not in IDLE
//  protocol_err  out  1       sticky: beat count / ret_last mismatch, or stray ret_valid
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; rd_req=0, busy=0, owner=0, protocol_err=0.
//   - rd_type/rd_addr registers cleared to 0; beat_cnt=0; last_grant=I (so D wins the first tie).
//   - All *_rdy and *_ret_valid/last outputs are 0.
//   - Mid-transaction reset abandons the burst; the bus is reset by the same signal.
//  FSM:
//   - IDLE -> REQ when i_rd_req|d_rd_req. Round-robin on a tie: grant the port != last_grant.
//     At the grant edge, latch owner, type and addr from the winner; update last_grant.
//   - REQ: rd_req=1 with the latched type/addr. owner_rd_rdy = rd_rdy (combinational); non-owner rdy=0.
//     On rd_rdy=1 -> RESP, beat_cnt=0.
//   - RESP: owner_ret_valid/last/data = bus ret_* (combinational passthrough); non-owner ret_valid/last=0, data=0.
//     beat_cnt++ on each ret_valid.
//     On ret_valid&ret_last -> IDLE. This is the same edge on which a new request may be granted; no bubble is required.
//  Latency:
//   - Request seen in IDLE at cycle N -> rd_req high at N+1.
//   - A requester that drops its req while in REQ is still served, because the latched values drive the bus.
//   - Requesters must hold req/type/addr until their rdy.
//  protocol_err (set, never cleared except by reset):
//   - ret_last on a beat where beat_cnt+1 != expected (1 or LINE_WORDS).
//   - ret_valid in IDLE or REQ (that beat is dropped, not forwarded).
//   - ret_last without ret_valid is ignored entirely.
//  Fairness: back-to-back requests from both ports alternate I/D/I/D; neither port waits more than one transaction.
//  busy = (state != IDLE).
// STRUCTURE
//  Package cache_bus_pkg:
//   - RD_TYPE_BYTE=3'b000, RD_TYPE_HALF=3'b001, RD_TYPE_WORD=3'b010, RD_TYPE_LINE=3'b100.
//   - arb state enum {IDLE, REQ, RESP}.
//   - Port-id constants PORT_I=0, PORT_D=1.
//  Sub-module rr_arb2: 2-way round-robin picker; inputs req[1:0] and last_grant; output grant id (combinational).
//  Everything else is a single always_ff FSM plus combinational steering.
// TESTING
//  1. Single I line read addr 0x1C000000, rd_rdy after 2 cycles, 4 beats 0xA0..0xA3 ->
//     i_ret_valid on 4 cycles with data 0xA0..0xA3, i_ret_last on the 4th; d_ret_valid stays 0; protocol_err=0.
//  2. I and D request in the same cycle after reset -> D granted first (rd_addr = d_rd_addr);
//     I granted on the edge D's ret_last arrives; rd_req high the next cycle.
//  3. Both ports request continuously for 6 transactions -> owner sequence D,I,D,I,D,I.
//  4. D word read (type 3'b010) with ret_last on the 2nd beat -> protocol_err=1 and stays 1 after further clean transactions.
//  5. ret_valid pulse while IDLE -> not forwarded to either port; protocol_err=1.
//  6. Assert reset during RESP beat 2 of a line -> all outputs 0 in the same cycle (async); after release, IDLE with busy=0;
//     a new I request is granted normally.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache read-channel arbiter.
//   RD_TYPE_*     : bus read request type encodings
//   arb_state_t   : arbiter FSM states
//   PORT_I/PORT_D : requester ids (owner encoding)
//   expected_beats: number of return beats a given request type produces
package cache_bus_pkg;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Line reads return line_words beats; every other type returns one.
    function automatic logic [7:0] expected_beats(input logic [2:0]  rd_type,
                                                  input int unsigned line_words);
        logic [7:0] beats;
        beats = 8'd1;
        if (rd_type == RD_TYPE_LINE) begin
            beats = line_words[7:0];
        end
        return beats;
    endfunction

endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker.
//   req[1:0]   : request vector, index = port id (0 = I, 1 = D)
//   last_grant : port id granted most recently
//   grant      : winning port id (meaningful only when |req)
module rr_arb2
    import cache_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = PORT_I;
        unique case (req)
            2'b01:   grant = PORT_I;
            2'b10:   grant = PORT_D;
            2'b11:   grant = ~last_grant;  // tie: the port not served last time
            default: grant = PORT_I;
        endcase
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one bus read channel between icache (I) and dcache (D).
//   i_* / d_*      : cache-side request and return ports
//   rd_req/type/addr, rd_rdy : bus request channel
//   ret_valid/last/data      : bus return channel
//   owner          : port currently holding the bus (0 = I, 1 = D), valid when busy
//   busy           : arbiter not idle
//   protocol_err   : sticky flag for beat-count mismatch or stray return beats
module cache_rd_arbiter
    import cache_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [DATA_W-1:0] i_ret_data,

    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [DATA_W-1:0] d_ret_data,

    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [DATA_W-1:0] ret_data,

    output logic              owner,
    output logic              busy,
    output logic              protocol_err
);

    arb_state_t        state;
    logic              owner_q;
    logic              last_grant;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        beat_cnt;
    logic              err_q;

    logic              grant_id;
    logic              any_req;
    logic              burst_end;
    logic              grant_go;
    logic              in_resp;

    rr_arb2 u_rr_arb2 (
        .req        ({d_rd_req, i_rd_req}),
        .last_grant (last_grant),
        .grant      (grant_id)
    );

    assign any_req   = i_rd_req | d_rd_req;
    assign in_resp   = (state == RESP);
    assign burst_end = in_resp & ret_valid & ret_last;
    // A new grant can be taken straight out of the closing beat of a burst.
    assign grant_go  = any_req & ((state == IDLE) | burst_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner_q    <= PORT_I;
            last_grant <= PORT_I;
            type_q     <= '0;
            addr_q     <= '0;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant_go) begin
                state      <= REQ;
                owner_q    <= grant_id;
                last_grant <= grant_id;
                type_q     <= (grant_id == PORT_D) ? d_rd_type : i_rd_type;
                addr_q     <= (grant_id == PORT_D) ? d_rd_addr : i_rd_addr;
            end else begin
                unique case (state)
                    IDLE: state <= IDLE;
                    REQ: begin
                        if (rd_rdy) begin
                            state    <= RESP;
                            beat_cnt <= '0;
                        end
                    end
                    RESP: begin
                        if (burst_end) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (in_resp && ret_valid) begin
                beat_cnt <= beat_cnt + 8'd1;
            end

            // Stray beats outside RESP are dropped but flagged.
            if (!in_resp && ret_valid) begin
                err_q <= 1'b1;
            end
            if (burst_end &&
                ((beat_cnt + 8'd1) != expected_beats(type_q, LINE_WORDS))) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_req       = (state == REQ);
        rd_type      = type_q;
        rd_addr      = addr_q;
        owner        = owner_q;
        busy         = (state != IDLE);
        protocol_err = err_q;

        i_rd_rdy     = rd_req & (owner_q == PORT_I) & rd_rdy;
        d_rd_rdy     = rd_req & (owner_q == PORT_D) & rd_rdy;

        i_ret_valid  = 1'b0;
        i_ret_last   = 1'b0;
        i_ret_data   = '0;
        d_ret_valid  = 1'b0;
        d_ret_last   = 1'b0;
        d_ret_data   = '0;
        if (in_resp) begin
            if (owner_q == PORT_I) begin
                i_ret_valid = ret_valid;
                i_ret_last  = ret_last;
                i_ret_data  = ret_data;
            end else begin
                d_ret_valid = ret_valid;
                d_ret_last  = ret_last;
                d_ret_data  = ret_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed self-checking bench for cache_rd_arbiter.
module tb_cache_rd_arbiter;

    localparam logic [2:0] T_WORD = 3'b010;
    localparam logic [2:0] T_LINE = 3'b100;

    logic        clk;
    logic        reset;
    logic        i_rd_req, d_rd_req;
    logic [2:0]  i_rd_type, d_rd_type;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [31:0] i_ret_data, d_ret_data;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;
    logic        owner, busy, protocol_err;

    int n_chk;
    int n_fail;

    cache_rd_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .LINE_WORDS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rd_req     (i_rd_req),
        .i_rd_type    (i_rd_type),
        .i_rd_addr    (i_rd_addr),
        .i_rd_rdy     (i_rd_rdy),
        .i_ret_valid  (i_ret_valid),
        .i_ret_last   (i_ret_last),
        .i_ret_data   (i_ret_data),
        .d_rd_req     (d_rd_req),
        .d_rd_type    (d_rd_type),
        .d_rd_addr    (d_rd_addr),
        .d_rd_rdy     (d_rd_rdy),
        .d_ret_valid  (d_ret_valid),
        .d_ret_last   (d_ret_last),
        .d_ret_data   (d_ret_data),
        .rd_req       (rd_req),
        .rd_type      (rd_type),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data),
        .owner        (owner),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one bus transaction starting in REQ: checks the request, waits
    // wait_cycles before rd_rdy, returns nbeats beats (last on the final one).
    task automatic bus_txn(input logic exp_owner, input logic [2:0] exp_type,
                           input logic [31:0] exp_addr, input int nbeats,
                           input logic [31:0] dbase, input logic drop_all,
                           input int wait_cycles);
        check("req_high",  {63'd0, rd_req}, 64'd1);
        check("owner",     {63'd0, owner}, {63'd0, exp_owner});
        check("rd_addr",   {32'd0, rd_addr}, {32'd0, exp_addr});
        check("rd_type",   {61'd0, rd_type}, {61'd0, exp_type});
        for (int w = 0; w < wait_cycles; w++) begin
            check("rdy_wait", {63'd0, exp_owner ? d_rd_rdy : i_rd_rdy}, 64'd0);
            tick();
        end
        rd_rdy = 1'b1;
        #1;
        check("own_rdy",   {63'd0, exp_owner ? d_rd_rdy : i_rd_rdy}, 64'd1);
        check("other_rdy", {63'd0, exp_owner ? i_rd_rdy : d_rd_rdy}, 64'd0);
        tick();
        rd_rdy = 1'b0;
        if (drop_all) begin
            i_rd_req = 1'b0;
            d_rd_req = 1'b0;
        end
        #1;
        check("req_low_resp", {63'd0, rd_req}, 64'd0);
        for (int k = 0; k < nbeats; k++) begin
            ret_valid = 1'b1;
            ret_data  = dbase + 32'(k);
            ret_last  = (k == nbeats - 1);
            #1;
            check("own_valid",   {63'd0, exp_owner ? d_ret_valid : i_ret_valid}, 64'd1);
            check("own_data",    {32'd0, exp_owner ? d_ret_data : i_ret_data}, {32'd0, dbase + 32'(k)});
            check("own_last",    {63'd0, exp_owner ? d_ret_last : i_ret_last}, (k == nbeats - 1) ? 64'd1 : 64'd0);
            check("other_valid", {63'd0, exp_owner ? i_ret_valid : d_ret_valid}, 64'd0);
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b0;
        i_rd_req = 1'b0; i_rd_type = '0; i_rd_addr = '0;
        d_rd_req = 1'b0; d_rd_type = '0; d_rd_addr = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy",   {63'd0, busy}, 64'd0);
        check("rst_rd_req", {63'd0, rd_req}, 64'd0);
        check("rst_owner",  {63'd0, owner}, 64'd0);
        check("rst_err",    {63'd0, protocol_err}, 64'd0);
        check("rst_addr",   {32'd0, rd_addr}, 64'd0);
        check("rst_type",   {61'd0, rd_type}, 64'd0);
        reset = 1'b1;

        // 1: single I line read, rdy after 2 cycles, 4 beats
        i_rd_req = 1'b1; i_rd_type = T_LINE; i_rd_addr = 32'h1C00_0000;
        #1;
        check("t1_req_lat", {63'd0, rd_req}, 64'd0);
        tick();
        check("t1_busy", {63'd0, busy}, 64'd1);
        bus_txn(1'b0, T_LINE, 32'h1C00_0000, 4, 32'hA0, 1'b1, 2);
        check("t1_idle", {63'd0, busy}, 64'd0);
        check("t1_err",  {63'd0, protocol_err}, 64'd0);

        // 2: simultaneous requests after reset: D first, I granted at D's last beat
        reset = 1'b0;
        #1;
        reset = 1'b1;
        i_rd_req = 1'b1; i_rd_type = T_WORD; i_rd_addr = 32'h0000_0100;
        d_rd_req = 1'b1; d_rd_type = T_WORD; d_rd_addr = 32'h0000_0200;
        tick();
        bus_txn(1'b1, T_WORD, 32'h0000_0200, 1, 32'h10, 1'b0, 0);
        bus_txn(1'b0, T_WORD, 32'h0000_0100, 1, 32'h20, 1'b1, 1);
        check("t2_idle", {63'd0, busy}, 64'd0);

        // 3: continuous requests from both ports alternate D,I,D,I,D,I
        i_rd_req = 1'b1; i_rd_addr = 32'h0000_1000;
        d_rd_req = 1'b1; d_rd_addr = 32'h0000_2000;
        tick();
        for (int t = 0; t < 6; t++) begin
            bus_txn((t % 2 == 0), T_WORD, (t % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000,
                    1, 32'h30 + 32'(t), (t == 5), 0);
        end
        check("t3_idle", {63'd0, busy}, 64'd0);
        check("t3_err",  {63'd0, protocol_err}, 64'd0);

        // 4: D word read with last on 2nd beat sets sticky error
        d_rd_req = 1'b1; d_rd_type = T_WORD; d_rd_addr = 32'h0000_0300;
        tick();
        bus_txn(1'b1, T_WORD, 32'h0000_0300, 2, 32'h50, 1'b1, 0);
        check("t4_err_set", {63'd0, protocol_err}, 64'd1);
        i_rd_req = 1'b1; i_rd_type = T_WORD; i_rd_addr = 32'h0000_0400;
        tick();
        bus_txn(1'b0, T_WORD, 32'h0000_0400, 1, 32'h60, 1'b1, 0);
        check("t4_err_sticky", {63'd0, protocol_err}, 64'd1);

        // 5: lone ret_last ignored; ret_valid in IDLE dropped and flagged
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        check("t5_err_clr", {63'd0, protocol_err}, 64'd0);
        ret_last = 1'b1;
        tick();
        ret_last = 1'b0;
        check("t5_last_only", {63'd0, protocol_err}, 64'd0);
        ret_valid = 1'b1; ret_data = 32'h77;
        #1;
        check("t5_i_valid", {63'd0, i_ret_valid}, 64'd0);
        check("t5_d_valid", {63'd0, d_ret_valid}, 64'd0);
        check("t5_i_data",  {32'd0, i_ret_data}, 64'd0);
        tick();
        ret_valid = 1'b0; ret_data = '0;
        check("t5_err", {63'd0, protocol_err}, 64'd1);
        check("t5_busy", {63'd0, busy}, 64'd0);

        // 6: async reset during beat 2 of an I line read
        reset = 1'b0;
        #1;
        reset = 1'b1;
        i_rd_req = 1'b1; i_rd_type = T_LINE; i_rd_addr = 32'h1C00_0040;
        tick();
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0; i_rd_req = 1'b0;
        ret_valid = 1'b1; ret_data = 32'hB0;
        tick();
        ret_data = 32'hB1;
        #1;
        check("t6_beat2", {63'd0, i_ret_valid}, 64'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", {63'd0, i_ret_valid}, 64'd0);
        check("t6_rst_data",  {32'd0, i_ret_data}, 64'd0);
        check("t6_rst_req",   {63'd0, rd_req}, 64'd0);
        check("t6_rst_busy",  {63'd0, busy}, 64'd0);
        check("t6_rst_addr",  {32'd0, rd_addr}, 64'd0);
        ret_valid = 1'b0; ret_data = '0;
        reset = 1'b1;
        tick();
        check("t6_idle", {63'd0, busy}, 64'd0);
        i_rd_req = 1'b1; i_rd_type = T_WORD; i_rd_addr = 32'h0000_0040;
        tick();
        bus_txn(1'b0, T_WORD, 32'h0000_0040, 1, 32'h90, 1'b1, 0);
        check("t6_done", {63'd0, busy}, 64'd0);
        check("t6_err",  {63'd0, protocol_err}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
